// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the RV32I immediate encoder and its matching extender.
// Contents: ImmSrc type codes, immediate field positions, sign-range check bit
// positions and a helper that tests whether the upper bits of a value are a
// pure sign extension.
package imm_encoder_pkg;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } imm_src_e;

   // Low bit of each contiguous immediate field inside the instruction word
   localparam int unsigned I_FIELD_LSB    = 20;
   localparam int unsigned S_HI_FIELD_LSB = 25;
   localparam int unsigned S_LO_FIELD_LSB = 7;
   localparam int unsigned B_HI_FIELD_LSB = 25;
   localparam int unsigned B_LO_FIELD_LSB = 8;
   localparam int unsigned J_HI_FIELD_LSB = 21;
   localparam int unsigned J_MID_FIELD_LSB = 12;

   // Lowest immediate bit that must equal the sign for the value to fit
   localparam int unsigned I_SIGN_LSB = 11;
   localparam int unsigned S_SIGN_LSB = 11;
   localparam int unsigned B_SIGN_LSB = 12;
   localparam int unsigned J_SIGN_LSB = 20;

   // True when v[31:lsb] are all zeros or all ones
   function automatic logic upper_uniform(input logic [31:0] v, input int unsigned lsb);
      logic [31:0] m;
      m = '1 << lsb;
      return ((v & m) == m) || ((v & m) == '0);
   endfunction

endpackage

// File: rtl/imm_encoder_scatter.sv
// imm_scatter: combinational immediate insertion and range check.
// Ports:
//   imm_i       32-bit two's complement byte offset
//   src_i       ImmSrc code (I/S/B/J)
//   template_i  instruction whose non-immediate bits are kept
//   instr_o     template with immediate bits scattered in
//   err_o       immediate does not fit, or is misaligned for B/J
module imm_scatter
   import imm_encoder_pkg::*;
(
   input  logic [31:0] imm_i,
   input  logic [1:0]  src_i,
   input  logic [31:0] template_i,
   output logic [31:0] instr_o,
   output logic        err_o
);

   always_comb begin
      instr_o = template_i;
      err_o   = 1'b0;
      case (src_i)
         IMM_I: begin
            instr_o[31:I_FIELD_LSB] = imm_i[11:0];
            err_o = !upper_uniform(imm_i, I_SIGN_LSB);
         end
         IMM_S: begin
            instr_o[31:S_HI_FIELD_LSB]             = imm_i[11:5];
            instr_o[S_LO_FIELD_LSB+4:S_LO_FIELD_LSB] = imm_i[4:0];
            err_o = !upper_uniform(imm_i, S_SIGN_LSB);
         end
         IMM_B: begin
            instr_o[31]                              = imm_i[12];
            instr_o[30:B_HI_FIELD_LSB]               = imm_i[10:5];
            instr_o[B_LO_FIELD_LSB+3:B_LO_FIELD_LSB] = imm_i[4:1];
            instr_o[7]                               = imm_i[11];
            err_o = imm_i[0] || !upper_uniform(imm_i, B_SIGN_LSB);
         end
         IMM_J: begin
            instr_o[31]                                = imm_i[20];
            instr_o[30:J_HI_FIELD_LSB]                 = imm_i[10:1];
            instr_o[20]                                = imm_i[11];
            instr_o[J_MID_FIELD_LSB+7:J_MID_FIELD_LSB] = imm_i[19:12];
            err_o = imm_i[0] || !upper_uniform(imm_i, J_SIGN_LSB);
         end
         default: begin
            instr_o = template_i;
            err_o   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage valid/ready pipeline that encodes an immediate into an
// RV32I instruction template and flags out-of-range immediates.
// Ports:
//   clk, rst                clock, asynchronous active-high reset
//   in_valid/in_ready       request handshake
//   in_imm, in_ImmSrc       immediate and its type code
//   in_template             instruction with non-immediate fields set
//   out_valid/out_ready     result handshake
//   out_instr, out_err      encoded instruction and range error
//   enc_count, err_count    saturating counts of delivered / erroneous results
module imm_encoder
   import imm_encoder_pkg::*;
#(
   parameter int unsigned width = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [width-1:0] in_imm,
   input  logic [1:0]       in_ImmSrc,
   input  logic [width-1:0] in_template,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [width-1:0] out_instr,
   output logic             out_err,
   output logic [CNT_W-1:0] enc_count,
   output logic [CNT_W-1:0] err_count
);

   logic [width-1:0] scat_instr;
   logic             scat_err;

   imm_scatter u_scatter (
      .imm_i      (in_imm),
      .src_i      (in_ImmSrc),
      .template_i (in_template),
      .instr_o    (scat_instr),
      .err_o      (scat_err)
   );

   logic             s1_valid_q, s1_valid_d;
   logic [width-1:0] s1_instr_q, s1_instr_d;
   logic             s1_err_q,   s1_err_d;
   logic             s2_valid_q, s2_valid_d;
   logic [width-1:0] s2_instr_q, s2_instr_d;
   logic             s2_err_q,   s2_err_d;
   logic [CNT_W-1:0] enc_cnt_q,  enc_cnt_d;
   logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;
   logic             s1_adv, s2_adv, out_fire;

   // A stage may load when it is empty or its content moves on this edge;
   // this makes in_ready combinational from out_ready so a full pipe still
   // sustains one transfer per clock.
   always_comb begin
      s2_adv   = !s2_valid_q || out_ready;
      s1_adv   = !s1_valid_q || s2_adv;
      out_fire = s2_valid_q && out_ready;
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_instr_d = s1_instr_q;
      s1_err_d   = s1_err_q;
      s2_valid_d = s2_valid_q;
      s2_instr_d = s2_instr_q;
      s2_err_d   = s2_err_q;
      enc_cnt_d  = enc_cnt_q;
      err_cnt_d  = err_cnt_q;

      if (s1_adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_instr_d = scat_instr;
            s1_err_d   = scat_err;
         end
      end

      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_instr_d = s1_instr_q;
            s2_err_d   = s1_err_q;
         end
      end

      if (out_fire) begin
         if (enc_cnt_q != '1)
            enc_cnt_d = enc_cnt_q + CNT_W'(1);
         if (s2_err_q && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_instr_q <= '0;
         s1_err_q   <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_instr_q <= '0;
         s2_err_q   <= 1'b0;
         enc_cnt_q  <= '0;
         err_cnt_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_instr_q <= s1_instr_d;
         s1_err_q   <= s1_err_d;
         s2_valid_q <= s2_valid_d;
         s2_instr_q <= s2_instr_d;
         s2_err_q   <= s2_err_d;
         enc_cnt_q  <= enc_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign in_ready  = s1_adv;
   assign out_valid = s2_valid_q;
   assign out_instr = s2_instr_q;
   assign out_err   = s2_err_q;
   assign enc_count = enc_cnt_q;
   assign err_count = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;

   localparam int unsigned CW = 4;
   localparam logic [1:0] SI = 2'b00, SS = 2'b01, SB = 2'b10, SJ = 2'b11;
   localparam int unsigned N_RAND = 10000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid, in_ready, out_valid, out_ready, out_err;
   logic [31:0]   in_imm, in_template, out_instr;
   logic [1:0]    in_ImmSrc;
   logic [CW-1:0] enc_count, err_count;

   always #5 clk = ~clk;

   imm_encoder #(.width(32), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_imm      (in_imm),
      .in_ImmSrc   (in_ImmSrc),
      .in_template (in_template),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_err     (out_err),
      .enc_count   (enc_count),
      .err_count   (err_count)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Which immediate bit lands at instruction bit p, or -1 if the template bit stays.
   function automatic int imm_pos(input logic [1:0] src, input int p);
      case (src)
         SI: if (p >= 20) return p - 20;
         SS: begin
            if (p >= 25) return p - 20;
            if (p >= 7 && p <= 11) return p - 7;
         end
         SB: begin
            if (p == 31) return 12;
            if (p >= 25) return p - 20;
            if (p >= 8 && p <= 11) return p - 7;
            if (p == 7) return 11;
         end
         default: begin
            if (p == 31) return 20;
            if (p >= 21) return p - 20;
            if (p == 20) return 11;
            if (p >= 12) return p;
         end
      endcase
      return -1;
   endfunction

   function automatic logic [31:0] model_enc(input logic [31:0] tmpl, input logic [31:0] imm,
                                             input logic [1:0] src);
      logic [31:0] r;
      r = tmpl;
      for (int p = 0; p < 32; p++) begin
         int k;
         k = imm_pos(src, p);
         if (k >= 0) r[p] = imm[k];
      end
      return r;
   endfunction

   function automatic logic [31:0] imm_mask(input logic [1:0] src);
      logic [31:0] m;
      m = '0;
      for (int p = 0; p < 32; p++)
         if (imm_pos(src, p) >= 0) m[p] = 1'b1;
      return m;
   endfunction

   function automatic logic model_err(input logic [31:0] imm, input logic [1:0] src);
      int v;
      v = imm;
      case (src)
         SI, SS:  return (v < -2048) || (v > 2047);
         SB:      return (v % 2 != 0) || (v < -4096) || (v > 4095);
         default: return (v % 2 != 0) || (v < -1048576) || (v > 1048575);
      endcase
   endfunction

   // The sign-extender this encoder inverts
   function automatic logic [31:0] model_ext(input logic [31:0] x, input logic [1:0] src);
      case (src)
         SI:      return {{20{x[31]}}, x[31:20]};
         SS:      return {{20{x[31]}}, x[31:25], x[11:7]};
         SB:      return {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
         default: return {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
      endcase
   endfunction

   function automatic logic [31:0] rand_imm();
      logic [31:0] edges [12];
      edges = '{32'h0000_07FF, 32'hFFFF_F800, 32'h0000_0800, 32'hFFFF_F7FF,
                32'h0000_0FFE, 32'h0000_1000, 32'hFFFF_F000, 32'hFFFF_EFFE,
                32'h000F_FFFE, 32'h0010_0000, 32'hFFF0_0000, 32'hFFEF_FFFE};
      case ($urandom_range(0, 3))
         0:       return $urandom();
         1:       return 32'($urandom_range(0, 8191)) - 32'd4096;
         2:       return 32'($urandom_range(0, 4194303)) - 32'd2097152;
         default: return edges[$urandom_range(0, 11)];
      endcase
   endfunction

   // ---------------- compare process ----------------
   typedef struct {
      logic [31:0] imm;
      logic [31:0] tmpl;
      logic [31:0] instr;
      logic [1:0]  src;
      logic        err;
   } txn_t;

   txn_t        q[$];
   int unsigned m_enc = 0, m_err = 0, delivered = 0;
   logic        hold_v = 1'b0;
   logic [31:0] hold_instr;
   logic        hold_err;

   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         m_enc  = 0;
         m_err  = 0;
         hold_v = 1'b0;
      end else begin
         txn_t t;
         check("enc_count", 32'(enc_count), m_enc);
         check("err_count", 32'(err_count), m_err);
         if (hold_v) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_instr", out_instr, hold_instr);
            check("hold_err", 32'(out_err), 32'(hold_err));
         end
         if (out_valid) begin
            if (q.size() == 0) begin
               check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
               t = q[0];
               check("out_instr", out_instr, t.instr);
               check("out_err", 32'(out_err), 32'(t.err));
               if (!t.err) check("round_trip", model_ext(out_instr, t.src), t.imm);
               check("tmpl_keep", out_instr & ~imm_mask(t.src), t.tmpl & ~imm_mask(t.src));
               if (out_ready) begin
                  void'(q.pop_front());
                  delivered++;
                  if (m_enc < (1 << CW) - 1) m_enc++;
                  if (t.err && m_err < (1 << CW) - 1) m_err++;
               end
            end
         end
         hold_v     = out_valid && !out_ready;
         hold_instr = out_instr;
         hold_err   = out_err;
         if (in_valid && in_ready) begin
            t.imm   = in_imm;
            t.tmpl  = in_template;
            t.src   = in_ImmSrc;
            t.instr = model_enc(in_template, in_imm, in_ImmSrc);
            t.err   = model_err(in_imm, in_ImmSrc);
            q.push_back(t);
         end
      end
   end

   // ---------------- stimulus ----------------
   // Called at posedge+1 with an empty pipe and out_ready=1.
   task automatic send(input string nm, input logic [31:0] tmpl, input logic [31:0] imm,
                       input logic [1:0] src, input logic [31:0] ex, input logic exe);
      in_valid    = 1'b1;
      in_template = tmpl;
      in_imm      = imm;
      in_ImmSrc   = src;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_imm   = $urandom();
      check({nm, "_lat1"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check({nm, "_valid"}, 32'(out_valid), 32'd1);
      check({nm, "_instr"}, out_instr, ex);
      check({nm, "_err"}, 32'(out_err), 32'(exe));
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      int          sent, first_drop, cyc, accepted;
      int unsigned base;
      in_valid = 1'b0; out_ready = 1'b0;
      in_imm = '0; in_template = '0; in_ImmSrc = '0;

      check("pin_enc_B", model_enc(32'h0000_0063, 32'hFFFF_FFFC, SB), 32'hFE00_0EE3);
      check("pin_err_I", 32'(model_err(32'h0000_0800, SI)), 32'd1);
      check("pin_err_Bodd", 32'(model_err(32'h0000_0003, SB)), 32'd1);
      check("pin_ext_J", model_ext(32'h0010_00EF, SJ), 32'h0000_0800);

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_out_err", 32'(out_err), 32'd0);
      check("rst_enc", 32'(enc_count), 32'd0);
      check("rst_err", 32'(err_count), 32'd0);
      rst = 1'b0;
      out_ready = 1'b1;

      // directed encodings
      send("I_neg1", 32'h0000_0093, 32'hFFFF_FFFF, SI, 32'hFFF0_0093, 1'b0);
      send("S_8",    32'h0020_A023, 32'h0000_0008, SS, 32'h0020_A423, 1'b0);
      send("B_m4",   32'h0000_0063, 32'hFFFF_FFFC, SB, 32'hFE00_0EE3, 1'b0);
      send("J_800",  32'h0000_00EF, 32'h0000_0800, SJ, 32'h0010_00EF, 1'b0);
      send("I_800",  32'h0000_0093, 32'h0000_0800, SI, 32'h8000_0093, 1'b1);
      send("B_3",    32'h0000_0063, 32'h0000_0003, SB, 32'h0000_0163, 1'b1);
      check("dir_enc_count", 32'(enc_count), 32'd6);
      check("dir_err_count", 32'(err_count), 32'd2);

      // backpressure: 5 back-to-back, consumer stalled for 4 clocks
      do_reset();
      base = delivered;
      sent = 0; first_drop = -1; cyc = 0;
      while (cyc < 60 && !(sent == 5 && delivered - base == 5)) begin
         out_ready   = (cyc >= 4);
         in_valid    = (sent < 5);
         in_template = 32'h0000_0013;
         in_imm      = 32'(sent + 1);
         in_ImmSrc   = SI;
         #3;
         if (in_valid && !in_ready && first_drop < 0) first_drop = sent;
         if (in_valid && in_ready) begin
            @(posedge clk); #1;
            sent++;
         end else begin
            @(posedge clk); #1;
         end
         cyc++;
      end
      in_valid = 1'b0;
      check("bp_drop_after", 32'(first_drop), 32'd2);
      check("bp_sent", 32'(sent), 32'd5);
      check("bp_delivered", delivered - base, 32'd5);
      check("bp_enc_count", 32'(enc_count), 32'd5);

      // reset with both stages full
      out_ready = 1'b0;
      in_valid = 1'b1; in_template = 32'h0000_0093; in_imm = 32'h0000_0800; in_ImmSrc = SI;
      @(posedge clk); #1;
      in_imm = 32'h0000_0005;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_out_valid", 32'(out_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_enc", 32'(enc_count), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("no_stale_out", 32'(out_valid), 32'd0);
      end

      // randomized traffic
      accepted = 0; cyc = 0;
      while (accepted < N_RAND && cyc < 40000) begin
         out_ready   = ($urandom_range(0, 3) != 0);
         in_valid    = ($urandom_range(0, 3) != 0);
         in_imm      = rand_imm();
         in_template = $urandom();
         in_ImmSrc   = 2'($urandom_range(0, 3));
         #3;
         if (in_valid && in_ready) accepted++;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rand_accepted", 32'(accepted), N_RAND);
      check("rand_drained", 32'(q.size()), 32'd0);
      check("sat_enc_count", 32'(enc_count), 32'd15);
      check("sat_err_count", 32'(err_count), 32'd15);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
